// File: rtl/synth_poly_core.sv
// Polyphonic keyboard synth: synchronised keys claim voices whose phase
// accumulators produce square/saw/triangle samples, mixed down to one PWM pin.
package synth_poly_core_pkg;
  localparam int INC_MAX_W = 1024;

  // Default increment table: entry k = 256 + 16*k, packed key 0 in the LSBs.
  function automatic logic [INC_MAX_W-1:0] inc_default(input int num_keys, input int acc_w);
    logic [INC_MAX_W-1:0] r;
    r = '0;
    for (int k = 0; k < num_keys; k++)
      r = r | (INC_MAX_W'(256 + 16 * k) << (k * acc_w));
    return r;
  endfunction
endpackage

module synth_poly_voice #(
  parameter int NUM_KEYS = 13,
  parameter int ACC_W    = 16,
  parameter int PWM_W    = 8,
  parameter int KEY_W    = 4,
  parameter logic [NUM_KEYS*ACC_W-1:0] INC_TABLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc,
  input  logic [KEY_W-1:0] alloc_key,
  input  logic [NUM_KEYS-1:0] held,
  input  logic [1:0]       octave,
  input  logic [1:0]       mode,
  output logic             active,
  output logic [KEY_W-1:0] key,
  output logic [PWM_W-1:0] sample
);
  logic [ACC_W-1:0] acc, inc, step;
  logic [PWM_W-1:0] t, fold;
  logic             msb, releasing;

  assign inc       = INC_TABLE[int'(key)*ACC_W +: ACC_W];
  assign step      = inc << octave;
  assign releasing = active & ~held[key];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= 1'b0;
      key    <= '0;
      acc    <= '0;
    end else if (alloc) begin
      active <= 1'b1;
      key    <= alloc_key;
      acc    <= '0;
    end else if (releasing || !active) begin
      active <= 1'b0;
      acc    <= '0;
    end else begin
      acc <= acc + step;
    end
  end

  assign msb  = acc[ACC_W-1];
  assign t    = acc[ACC_W-1 -: PWM_W];
  assign fold = msb ? ~t : t;

  always_comb begin
    sample = '0;
    if (active) begin
      case (mode)
        2'd0:    sample = {PWM_W{msb}};
        2'd1:    sample = t;
        2'd2:    sample = {fold[PWM_W-2:0], 1'b0};
        default: sample = '0;
      endcase
    end
  end
endmodule

module synth_poly_core #(
  parameter int NUM_KEYS   = 13,
  parameter int NUM_VOICES = 4,
  parameter int ACC_W      = 16,
  parameter int PWM_W      = 8,
  parameter logic [NUM_KEYS*ACC_W-1:0] INC_TABLE =
    (NUM_KEYS*ACC_W)'(synth_poly_core_pkg::inc_default(NUM_KEYS, ACC_W))
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_KEYS-1:0]   pb,
  input  logic                  mode_btn,
  input  logic                  octave_btn,
  output logic                  pwm_o,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic [1:0]            mode_o,
  output logic [1:0]            octave_o
);
  localparam int KEY_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int SHIFT = $clog2(NUM_VOICES);
  localparam int SUM_W = PWM_W + SHIFT;

  logic [NUM_KEYS-1:0] pb_meta, pb_sync;
  logic mode_meta, mode_sync, mode_prev;
  logic oct_meta, oct_sync, oct_prev;
  logic mode_edge, oct_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pb_meta   <= '0;
      pb_sync   <= '0;
      mode_meta <= 1'b0;
      mode_sync <= 1'b0;
      mode_prev <= 1'b0;
      oct_meta  <= 1'b0;
      oct_sync  <= 1'b0;
      oct_prev  <= 1'b0;
    end else begin
      pb_meta   <= pb;
      pb_sync   <= pb_meta;
      mode_meta <= mode_btn;
      mode_sync <= mode_meta;
      mode_prev <= mode_sync;
      oct_meta  <= octave_btn;
      oct_sync  <= oct_meta;
      oct_prev  <= oct_sync;
    end
  end

  assign mode_edge = mode_sync & ~mode_prev;
  assign oct_edge  = oct_sync & ~oct_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_o   <= 2'd0;
      octave_o <= 2'd0;
    end else begin
      if (mode_edge) mode_o <= (mode_o == 2'd2) ? 2'd0 : mode_o + 2'd1;
      if (oct_edge)  octave_o <= octave_o + 2'd1;
    end
  end

  logic [NUM_VOICES-1:0]            v_active, alloc;
  logic [NUM_VOICES-1:0][KEY_W-1:0] v_key;
  logic [NUM_VOICES-1:0][PWM_W-1:0] v_sample;
  logic [NUM_KEYS-1:0]              assigned, pending;
  logic [KEY_W-1:0]                 key_sel;
  logic                             key_found, voice_found;
  int                               voice_sel;

  // A voice freed by a release this cycle is not reused until the next one,
  // so a release always shows as one cycle of silence on voice_active.
  always_comb begin
    assigned = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      for (int v = 0; v < NUM_VOICES; v++)
        if (v_active[v] && v_key[v] == KEY_W'(k)) assigned[k] = 1'b1;
    pending = pb_sync & ~assigned;

    key_sel   = '0;
    key_found = 1'b0;
    for (int k = NUM_KEYS-1; k >= 0; k--)
      if (pending[k]) begin
        key_sel   = KEY_W'(k);
        key_found = 1'b1;
      end

    voice_sel   = 0;
    voice_found = 1'b0;
    for (int v = NUM_VOICES-1; v >= 0; v--)
      if (!v_active[v]) begin
        voice_sel   = v;
        voice_found = 1'b1;
      end

    alloc = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      alloc[v] = key_found && voice_found && (voice_sel == v);
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    synth_poly_voice #(
      .NUM_KEYS (NUM_KEYS),
      .ACC_W    (ACC_W),
      .PWM_W    (PWM_W),
      .KEY_W    (KEY_W),
      .INC_TABLE(INC_TABLE)
    ) u_voice (
      .clk      (clk),
      .reset    (reset),
      .alloc    (alloc[v]),
      .alloc_key(key_sel),
      .held     (pb_sync),
      .octave   (octave_o),
      .mode     (mode_o),
      .active   (v_active[v]),
      .key      (v_key[v]),
      .sample   (v_sample[v])
    );
  end

  assign voice_active = v_active;

  logic [SUM_W-1:0] sum;
  logic [PWM_W-1:0] mix, cnt, duty;

  always_comb begin
    sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) sum = sum + SUM_W'(v_sample[v]);
  end

  assign mix = PWM_W'(sum >> SHIFT);

  // Duty only changes at the end of a PWM period to avoid glitched pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      duty  <= '0;
      pwm_o <= 1'b0;
    end else begin
      cnt   <= cnt + PWM_W'(1);
      if (cnt == '1) duty <= mix;
      pwm_o <= (cnt < duty);
    end
  end
endmodule
